branch_logic: RTL and testbench

- Evaluates a 3-bit branch condition code against the 4-bit status flags (C, Z, N, V) and reports whether the branch is taken.
- Sits beside the control unit. The control unit consumes the combinational `result` in its OPERAND_FETCH state to drive `pc_branch_wr`.
- Also provides a registered copy of the result, a one-hot condition decode, and optional taken/evaluated statistics counters.

---
 rtl/branch_logic.sv | 73 +++++++
 tb/tb_branch_logic.sv | 133 +++++++++++++
 2 files changed

// File: rtl/branch_logic.sv
// branch_logic: evaluates a 3-bit branch condition against C/Z/N/V flags, with a registered copy.
// Define BRANCH_LOGIC_STATS_EN to add saturating taken/evaluated counters.
module branch_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       status,
    input  logic [2:0]       branch_cond,
    input  logic             eval_en,
    output logic             result,
    output logic [7:0]       cond_onehot,
    output logic             result_q,
`ifdef BRANCH_LOGIC_STATS_EN
    output logic             result_valid,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] eval_count
`else
    output logic             result_valid
`endif
);
    logic valid_q;
    logic result_d;

    always_comb begin
        result = 1'b1;
        case (branch_cond)
            3'd0:    result = status[1];
            3'd1:    result = !status[1];
            3'd2:    result = status[0];
            3'd3:    result = !status[0];
            3'd4:    result = status[2];
            3'd5:    result = status[2] == status[3];
            3'd6:    result = status[2] != status[3];
            default: result = 1'b1;
        endcase
    end

    assign cond_onehot  = 8'b1 << branch_cond;
    assign result_d     = eval_en ? result : result_q;
    assign result_valid = valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= eval_en;
        end
    end

`ifdef BRANCH_LOGIC_STATS_EN
    logic [CNT_W-1:0] eval_q, eval_d, taken_q, taken_d;

    // each counter saturates independently at all-ones
    assign eval_d  = (eval_en && eval_q != '1) ? eval_q + CNT_W'(1) : eval_q;
    assign taken_d = (eval_en && result && taken_q != '1) ? taken_q + CNT_W'(1) : taken_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eval_q  <= '0;
            taken_q <= '0;
        end else begin
            eval_q  <= eval_d;
            taken_q <= taken_d;
        end
    end

    assign eval_count  = eval_q;
    assign taken_count = taken_q;
`endif
endmodule

// File: tb/tb_branch_logic.sv
// tb_branch_logic: directed self-checking bench for branch_logic (stats checks when BRANCH_LOGIC_STATS_EN is defined).
module tb_branch_logic;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] status;
    logic [2:0] branch_cond;
    logic       eval_en;
    logic       result;
    logic [7:0] cond_onehot;
    logic       result_q;
    logic       result_valid;
`ifdef BRANCH_LOGIC_STATS_EN
    logic [3:0] taken_count;
    logic [3:0] eval_count;
`endif
    int total = 0;
    int bad = 0;
    // bit s of tbl[c] is the expected result for branch_cond=c, status=s
    logic [15:0] tbl [8] = '{16'hCCCC, 16'h3333, 16'hAAAA, 16'h5555,
                             16'hF0F0, 16'hF00F, 16'h0FF0, 16'hFFFF};
    logic [15:0] row;

    branch_logic #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .status(status), .branch_cond(branch_cond),
        .eval_en(eval_en), .result(result), .cond_onehot(cond_onehot),
        .result_q(result_q),
`ifdef BRANCH_LOGIC_STATS_EN
        .result_valid(result_valid), .taken_count(taken_count), .eval_count(eval_count)
`else
        .result_valid(result_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        status = 4'h0;
        branch_cond = 3'd0;
        eval_en = 1'b1;
        @(negedge clk);
        chk("reset_result_q", result_q, 0);
        chk("reset_valid", result_valid, 0);
        eval_en = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            row = tbl[c];
            for (int s = 0; s < 16; s++) begin
                branch_cond = 3'(c);
                status = 4'(s);
                #1;
                chk($sformatf("result_c%0d_s%0d", c, s), result, row[s]);
            end
            chk($sformatf("onehot_c%0d", c), cond_onehot, 32'd1 << c);
        end
        branch_cond = 3'd7;
        status = 4'bxxxx;
        #1;
        chk("always_x_result", result, 1);
        chk("always_x_onehot", cond_onehot, 8'h80);
        @(negedge clk);
        branch_cond = 3'd2;
        status = 4'b0001;
        eval_en = 1'b1;
        @(negedge clk);
        chk("cap_result_q", result_q, 1);
        chk("cap_valid", result_valid, 1);
        branch_cond = 3'd3;
        eval_en = 1'b0;
        @(negedge clk);
        chk("hold_result_q", result_q, 1);
        chk("hold_valid", result_valid, 0);
        eval_en = 1'b1;
        @(negedge clk);
        chk("b2b0_result_q", result_q, 0);
        chk("b2b0_valid", result_valid, 1);
        branch_cond = 3'd2;
        @(negedge clk);
        chk("b2b1_result_q", result_q, 1);
        chk("b2b1_valid", result_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_result_q", result_q, 0);
        chk("async_valid", result_valid, 0);
        chk("async_comb_result", result, 1);
        branch_cond = 3'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            eval_en = ~eval_en;
            chk("inrst_result_q", result_q, 0);
            chk("inrst_valid", result_valid, 0);
        end
        eval_en = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("release_result_q", result_q, 1);
        chk("release_valid", result_valid, 1);
`ifdef BRANCH_LOGIC_STATS_EN
        eval_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("stats_rst_eval", eval_count, 0);
        chk("stats_rst_taken", taken_count, 0);
        @(negedge clk);
        reset = 1'b1;
        eval_en = 1'b1;
        branch_cond = 3'd7;
        repeat (10) @(negedge clk);
        chk("stats10_eval", eval_count, 10);
        chk("stats10_taken", taken_count, 10);
        branch_cond = 3'd1;
        status = 4'b0010;
        repeat (3) @(negedge clk);
        chk("stats13_eval", eval_count, 13);
        chk("stats13_taken", taken_count, 10);
        branch_cond = 3'd7;
        repeat (20) @(negedge clk);
        chk("stats_sat_eval", eval_count, 15);
        chk("stats_sat_taken", taken_count, 15);
        eval_en = 1'b0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
